// File: rtl/logic_unit_pipe_if.sv
// Request/result bundle for the pipelined logic unit.
// Master side issues operands and accepts results; slave side is the unit.
// IN_VALID/IN_READY gate requests, Logic_Flag/OUT_READY gate results.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       ALU_FUNC;
    logic             IN_VALID;
    logic             IN_READY;
    logic             OUT_READY;
    logic [WIDTH-1:0] Logic_OUT;
    logic             Logic_Flag;
    logic             Zero_Flag;
    logic             Parity_Flag;

    modport master (
        output A, B, ALU_FUNC, IN_VALID, OUT_READY,
        input  IN_READY, Logic_OUT, Logic_Flag, Zero_Flag, Parity_Flag
    );

    modport slave (
        input  A, B, ALU_FUNC, IN_VALID, OUT_READY,
        output IN_READY, Logic_OUT, Logic_Flag, Zero_Flag, Parity_Flag
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined 8-function bitwise logic unit with zero/parity flags.
// Latency: result valid one edge after the accepting edge (two stages, 1/cycle).
// Backpressure: holds up to two requests; IN_READY drops only when both stages full and OUT_READY=0.
module logic_unit_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    logic_unit_pipe_if.slave bus
);

    // stage 1: operand register
    logic             r_s1_vld;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_func;

    // stage 2: result register
    logic             r_s2_vld;
    logic [WIDTH-1:0] r_res;
    logic             r_zero;
    logic             r_par;

    logic             w_s2_free;
    logic             w_in_rdy;
    logic             w_in_xfer;
    logic             w_move;
    logic             w_out_xfer;
    logic [WIDTH-1:0] w_res;
    logic             w_zero;
    logic             w_par;

    // Stage 2 can take new data if empty or draining this cycle; the input
    // side sees that through IN_READY, which is the only comb in->out path.
    assign w_s2_free  = !r_s2_vld || bus.OUT_READY;
    assign w_in_rdy   = !i_rst && (!r_s1_vld || w_s2_free);
    assign w_in_xfer  = bus.IN_VALID && w_in_rdy;
    assign w_move     = r_s1_vld && w_s2_free;
    assign w_out_xfer = r_s2_vld && bus.OUT_READY;

    // Function decode from the registered operands; all eight codes are legal.
    always_comb begin
        w_res = '0;
        unique case (r_func)
            3'b000:  w_res = r_a & r_b;
            3'b001:  w_res = r_a | r_b;
            3'b010:  w_res = ~(r_a & r_b);
            3'b011:  w_res = ~(r_a | r_b);
            3'b100:  w_res = r_a ^ r_b;
            3'b101:  w_res = ~(r_a ^ r_b);
            3'b110:  w_res = r_a & ~r_b;
            default: w_res = ~r_a;
        endcase
        w_zero = (w_res == '0);
        w_par  = ^w_res;
    end

    // Stage 1: capture operands on input transfer, otherwise empty on handoff.
    // Operand registers keep their old content after handoff.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_vld <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_func   <= '0;
        end else if (w_in_xfer) begin
            r_s1_vld <= 1'b1;
            r_a      <= bus.A;
            r_b      <= bus.B;
            r_func   <= bus.ALU_FUNC;
        end else if (w_move) begin
            r_s1_vld <= 1'b0;
        end
    end

    // Stage 2: capture result and flags on handoff, otherwise clear valid on
    // output transfer; data is left untouched so a stall is bit-stable.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_vld <= 1'b0;
            r_res    <= '0;
            r_zero   <= 1'b0;
            r_par    <= 1'b0;
        end else if (w_move) begin
            r_s2_vld <= 1'b1;
            r_res    <= w_res;
            r_zero   <= w_zero;
            r_par    <= w_par;
        end else if (w_out_xfer) begin
            r_s2_vld <= 1'b0;
        end
    end

    assign bus.IN_READY    = w_in_rdy;
    assign bus.Logic_OUT   = r_res;
    assign bus.Logic_Flag  = r_s2_vld;
    assign bus.Zero_Flag   = r_zero;
    assign bus.Parity_Flag = r_par;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe at WIDTH=8 and WIDTH=13.
// Directed scenarios on the 8-bit unit, randomized scoreboard runs on both.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_logic_unit_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(8))  b8 ();
    logic_unit_pipe_if #(.WIDTH(13)) b13 ();

    logic_unit_pipe #(.WIDTH(8)) dut8 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (b8)
    );

    logic_unit_pipe #(.WIDTH(13)) dut13 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (b13)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [15:0] res;
        int          age;
    } exp_t;

    // Reference: the function table evaluated at full 16 bits, then trimmed to w.
    function automatic logic [15:0] ref_res(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input int f);
        logic [15:0] r;
        logic [15:0] m;
        m = (16'h1 << w) - 16'h1;
        case (f)
            0:       r = a & b;
            1:       r = a | b;
            2:       r = ~(a & b);
            3:       r = ~(a | b);
            4:       r = a ^ b;
            5:       r = ~(a ^ b);
            6:       r = a & ~b;
            default: r = ~a;
        endcase
        return r & m;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        b8.IN_VALID = 1'b1; b8.A = 8'hFF; b8.B = 8'h00; b8.ALU_FUNC = 3'b001; b8.OUT_READY = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (b8.IN_READY !== 1'b0) $display("FAIL reset_in_ready got=%b want=0", b8.IN_READY); else n_pass++;
        n_checks++;
        if (b8.Logic_Flag !== 1'b0) $display("FAIL reset_flag got=%b want=0", b8.Logic_Flag); else n_pass++;
        n_checks++;
        if (b8.Logic_OUT !== 8'h00) $display("FAIL reset_out got=%h want=00", b8.Logic_OUT); else n_pass++;
        n_checks++;
        if ({b8.Zero_Flag, b8.Parity_Flag} !== 2'b00)
            $display("FAIL reset_zp got=%b%b want=00", b8.Zero_Flag, b8.Parity_Flag); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        b8.IN_VALID = 1'b0;
        @(negedge clk);
        n_checks++;
        if (b8.IN_READY !== 1'b1) $display("FAIL post_reset_in_ready got=%b want=1", b8.IN_READY); else n_pass++;
        n_checks++;
        if (b8.Logic_Flag !== 1'b0) $display("FAIL post_reset_flag got=%b want=0", b8.Logic_Flag); else n_pass++;
    endtask

    task automatic test_func_sweep();
        logic [7:0] exp_v [8];
        exp_v = '{8'h30, 8'hFC, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'hC0, 8'h0F};
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            b8.OUT_READY = 1'b1;
            b8.IN_VALID  = (c < 8);
            b8.A = 8'hF0; b8.B = 8'h3C; b8.ALU_FUNC = 3'(c);
            @(negedge clk);
            if (c < 8) begin
                n_checks++;
                if (b8.IN_READY !== 1'b1) $display("FAIL sweep_in_ready c=%0d got=%b want=1", c, b8.IN_READY); else n_pass++;
            end
            if (c < 2) begin
                n_checks++;
                if (b8.Logic_Flag !== 1'b0) $display("FAIL sweep_early_flag c=%0d got=%b want=0", c, b8.Logic_Flag); else n_pass++;
            end else begin
                n_checks++;
                if (b8.Logic_Flag !== 1'b1) $display("FAIL sweep_flag f=%0d got=%b want=1", c-2, b8.Logic_Flag); else n_pass++;
                n_checks++;
                if (b8.Logic_OUT !== exp_v[c-2])
                    $display("FAIL sweep_out f=%0d got=%h want=%h", c-2, b8.Logic_OUT, exp_v[c-2]); else n_pass++;
                n_checks++;
                if ({b8.Zero_Flag, b8.Parity_Flag} !== 2'b00)
                    $display("FAIL sweep_zp f=%0d got=%b%b want=00", c-2, b8.Zero_Flag, b8.Parity_Flag); else n_pass++;
            end
        end
        b8.IN_VALID = 1'b0;
    endtask

    task automatic test_flags();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            b8.OUT_READY = 1'b1;
            b8.IN_VALID  = (c < 2);
            if (c == 0) begin b8.A = 8'hA5; b8.B = 8'hA5; b8.ALU_FUNC = 3'b100; end
            else        begin b8.A = 8'h01; b8.B = 8'h00; b8.ALU_FUNC = 3'b001; end
            @(negedge clk);
            if (c == 2) begin
                n_checks++;
                if ({b8.Logic_Flag, b8.Logic_OUT, b8.Zero_Flag, b8.Parity_Flag} !== {1'b1, 8'h00, 1'b1, 1'b0})
                    $display("FAIL flags_xor got=%b/%h/z%b/p%b want=1/00/z1/p0",
                             b8.Logic_Flag, b8.Logic_OUT, b8.Zero_Flag, b8.Parity_Flag); else n_pass++;
            end
            if (c == 3) begin
                n_checks++;
                if ({b8.Logic_Flag, b8.Logic_OUT, b8.Zero_Flag, b8.Parity_Flag} !== {1'b1, 8'h01, 1'b0, 1'b1})
                    $display("FAIL flags_or got=%b/%h/z%b/p%b want=1/01/z0/p1",
                             b8.Logic_Flag, b8.Logic_OUT, b8.Zero_Flag, b8.Parity_Flag); else n_pass++;
            end
        end
        b8.IN_VALID = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] got[$];
        int idx;
        idx = 0;
        b8.B = 8'h00; b8.ALU_FUNC = 3'b100;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            b8.OUT_READY = (c >= 6);
            b8.IN_VALID  = (idx < 5);
            b8.A = 8'(8'h11 * (idx + 1));
            @(negedge clk);
            if (c >= 2 && c <= 5) begin
                n_checks++;
                if ({b8.Logic_Flag, b8.Logic_OUT} !== {1'b1, 8'h11})
                    $display("FAIL bp_stall_hold c=%0d got=%b/%h want=1/11", c, b8.Logic_Flag, b8.Logic_OUT); else n_pass++;
            end
            if (c == 5) begin
                n_checks++;
                if (idx != 2) $display("FAIL bp_accepts got=%0d want=2", idx); else n_pass++;
                n_checks++;
                if (b8.IN_READY !== 1'b0) $display("FAIL bp_in_ready_low got=%b want=0", b8.IN_READY); else n_pass++;
            end
            if (c == 6) begin
                n_checks++;
                if (b8.IN_READY !== 1'b1) $display("FAIL bp_in_ready_rise got=%b want=1", b8.IN_READY); else n_pass++;
            end
            if (b8.Logic_Flag && b8.OUT_READY) got.push_back(b8.Logic_OUT);
            if (b8.IN_VALID && b8.IN_READY) idx++;
        end
        b8.IN_VALID = 1'b0;
        n_checks++;
        if (got.size() != 5) $display("FAIL bp_drain_count got=%0d want=5", got.size()); else n_pass++;
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== 8'(8'h11 * (i + 1)))
                $display("FAIL bp_drain_order i=%0d got=%h want=%h", i, got[i], 8'(8'h11 * (i + 1))); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            b8.OUT_READY = 1'b0; b8.IN_VALID = 1'b1;
            b8.A = 8'(8'h70 + c); b8.B = 8'h00; b8.ALU_FUNC = 3'b001;
            @(negedge clk);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        b8.IN_VALID = 1'b1; b8.A = 8'hFF; b8.ALU_FUNC = 3'b111;
        @(negedge clk);
        n_checks++;
        if (b8.IN_READY !== 1'b0) $display("FAIL rstmid_in_ready got=%b want=0", b8.IN_READY); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        b8.OUT_READY = 1'b1;
        b8.A = 8'h5A; b8.B = 8'h0F; b8.ALU_FUNC = 3'b000;
        @(negedge clk);
        n_checks++;
        if ({b8.Logic_Flag, b8.Logic_OUT} !== {1'b0, 8'h00})
            $display("FAIL rstmid_cleared got=%b/%h want=0/00", b8.Logic_Flag, b8.Logic_OUT); else n_pass++;
        n_checks++;
        if (b8.IN_READY !== 1'b1) $display("FAIL rstmid_in_ready_after got=%b want=1", b8.IN_READY); else n_pass++;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(posedge clk); #1;
            b8.IN_VALID = 1'b0;
            @(negedge clk);
            if (b8.Logic_Flag) begin
                seen = 1'b1;
                n_checks++;
                if (b8.Logic_OUT !== 8'h0A) $display("FAIL rstmid_first_result got=%h want=0a", b8.Logic_OUT); else n_pass++;
            end
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL rstmid_timeout got=no_result want=0a");
        end
    endtask

    task automatic test_random(input int sel, input int ncyc);
        exp_t        q[$];
        exp_t        e;
        int          w;
        logic [15:0] mask, a, b, ob, prev_out;
        logic [2:0]  f;
        logic        v, o, oflag, ordy, oz, op, exp_rdy, exp_flag;
        logic        prev_stall, prev_z, prev_p;
        w    = (sel == 0) ? 8 : 13;
        mask = (16'h1 << w) - 16'h1;
        // start from an empty pipe
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            b8.IN_VALID = 1'b0; b8.OUT_READY = 1'b1;
            b13.IN_VALID = 1'b0; b13.OUT_READY = 1'b1;
        end
        prev_stall = 1'b0; prev_out = '0; prev_z = 1'b0; prev_p = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            v = ($urandom_range(0, 3) != 0);
            o = (c < ncyc/2) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 2) == 0);
            a = 16'($urandom) & mask;
            b = 16'($urandom) & mask;
            f = 3'($urandom_range(0, 7));
            if (sel == 0) begin
                b8.IN_VALID = v; b8.OUT_READY = o; b8.A = a[7:0]; b8.B = b[7:0]; b8.ALU_FUNC = f;
            end else begin
                b13.IN_VALID = v; b13.OUT_READY = o; b13.A = a[12:0]; b13.B = b[12:0]; b13.ALU_FUNC = f;
            end
            @(negedge clk);
            ob    = (sel == 0) ? {8'h00, b8.Logic_OUT} : {3'b000, b13.Logic_OUT};
            oflag = (sel == 0) ? b8.Logic_Flag  : b13.Logic_Flag;
            ordy  = (sel == 0) ? b8.IN_READY    : b13.IN_READY;
            oz    = (sel == 0) ? b8.Zero_Flag   : b13.Zero_Flag;
            op    = (sel == 0) ? b8.Parity_Flag : b13.Parity_Flag;
            exp_rdy  = (q.size() < 2) || o;
            exp_flag = (q.size() > 0) && (q[0].age >= 1);
            n_checks++;
            if (ordy !== exp_rdy) $display("FAIL rand_w%0d_in_ready c=%0d got=%b want=%b", w, c, ordy, exp_rdy); else n_pass++;
            n_checks++;
            if (oflag !== exp_flag) $display("FAIL rand_w%0d_flag c=%0d got=%b want=%b", w, c, oflag, exp_flag); else n_pass++;
            if (exp_flag) begin
                n_checks++;
                if ({ob, oz, op} !== {q[0].res, q[0].res == 16'h0, ^q[0].res})
                    $display("FAIL rand_w%0d_result c=%0d got=%h/z%b/p%b want=%h/z%b/p%b", w, c, ob, oz, op,
                             q[0].res, q[0].res == 16'h0, ^q[0].res); else n_pass++;
            end
            if (prev_stall) begin
                n_checks++;
                if ({ob, oz, op} !== {prev_out, prev_z, prev_p})
                    $display("FAIL rand_w%0d_stall c=%0d got=%h/%b%b want=%h/%b%b", w, c, ob, oz, op,
                             prev_out, prev_z, prev_p); else n_pass++;
            end
            prev_stall = oflag && !o;
            prev_out = ob; prev_z = oz; prev_p = op;
            if (exp_flag && o) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (v && exp_rdy) begin
                e.res = ref_res(w, a, b, int'(f));
                e.age = 0;
                q.push_back(e);
            end
        end
        @(posedge clk); #1;
        b8.IN_VALID = 1'b0; b13.IN_VALID = 1'b0;
        b8.OUT_READY = 1'b1; b13.OUT_READY = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1;
        b8.IN_VALID = 1'b0; b8.OUT_READY = 1'b1; b8.A = '0; b8.B = '0; b8.ALU_FUNC = '0;
        b13.IN_VALID = 1'b0; b13.OUT_READY = 1'b1; b13.A = '0; b13.B = '0; b13.ALU_FUNC = '0;
        test_reset();
        test_func_sweep();
        test_flags();
        test_backpressure();
        test_reset_mid();
        test_random(0, 600);
        test_random(1, 600);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
